vgalcd_tim_meas: RTL and testbench

//  Timing measurement for one VGA/LCD axis; the receive-side inverse of the timing counter.

---
 rtl/vgalcd_tim_meas_if.sv | 29 ++
 rtl/vgalcd_tim_meas.sv | 184 ++++++++++++++++++
 tb/tb_vgalcd_tim_meas.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vgalcd_tim_meas_if.sv
// Sample-side bundle for one measured video timing axis.
// Master drives the sampled sync/visible pair; slave returns the measurements.
interface vgalcd_tim_meas_if #(
    parameter int TB_WIDTH = 16,
    parameter int VB_WIDTH = 16
);
    logic                en_i;
    logic                sync_i;
    logic                vis_i;
    logic [TB_WIDTH-1:0] bpsize_o;
    logic [TB_WIDTH-1:0] snsize_o;
    logic [TB_WIDTH-1:0] fpsize_o;
    logic [VB_WIDTH-1:0] vlen_o;
    logic                valid_o;
    logic                lock_o;
    logic                err_o;

    modport master (
        output en_i, sync_i, vis_i,
        input  bpsize_o, snsize_o, fpsize_o, vlen_o,
        input  valid_o, lock_o, err_o
    );

    modport slave (
        input  en_i, sync_i, vis_i,
        output bpsize_o, snsize_o, fpsize_o, vlen_o,
        output valid_o, lock_o, err_o
    );
endinterface

// File: rtl/vgalcd_tim_meas.sv
// Receive-side timing measurement for one VGA/LCD axis.
// Reports phase lengths in N-1 form, with per-period valid, lock and error.
module vgalcd_tim_meas #(
    parameter int TB_WIDTH = 16,
    parameter int VB_WIDTH = 16,
    parameter int LOCK_CNT = 2
) (
    input logic clk_i,
    input logic rst_n_i,
    vgalcd_tim_meas_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [TB_WIDTH-1:0] T1 = TB_WIDTH'(1);
    localparam logic [VB_WIDTH-1:0] V1 = VB_WIDTH'(1);
    localparam logic [MW-1:0]       M1 = MW'(1);
    localparam logic [MW-1:0]       LK = MW'(LOCK_CNT);

    typedef enum logic [2:0] {
        IDLE, SYNC, BACKPORCH, VISIBLE, FRONTPORCH
    } state_t;

    state_t              state, state_n;
    logic                armed, armed_n;
    logic [TB_WIDTH-1:0] sn_cnt, bp_cnt, fp_cnt;
    logic [TB_WIDTH-1:0] sn_n, bp_n, fp_n;
    logic [VB_WIDTH-1:0] vc_cnt, vc_n;
    logic [TB_WIDTH-1:0] sn_new, bp_new, fp_new;
    logic [VB_WIDTH-1:0] vl_new;
    logic [MW-1:0]       match, match_n;
    logic                done, fault, same;
    logic                s, v;

    assign s = bus.sync_i;
    assign v = bus.vis_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else if (bus.en_i) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        armed_n = armed;
        sn_n    = sn_cnt;
        bp_n    = bp_cnt;
        fp_n    = fp_cnt;
        vc_n    = vc_cnt;
        done    = 1'b0;
        fault   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!s) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = SYNC;
                    sn_n    = T1;
                    armed_n = 1'b0;
                end
            end
            SYNC: begin
                if (v) begin
                    fault = 1'b1;
                end else if (!s) begin
                    state_n = BACKPORCH;
                    bp_n    = T1;
                end else if (&sn_cnt) begin
                    fault = 1'b1;
                end else begin
                    sn_n = sn_cnt + T1;
                end
            end
            BACKPORCH: begin
                if (s) begin
                    fault = 1'b1;
                end else if (v) begin
                    state_n = VISIBLE;
                    vc_n    = V1;
                end else if (&bp_cnt) begin
                    fault = 1'b1;
                end else begin
                    bp_n = bp_cnt + T1;
                end
            end
            VISIBLE: begin
                if (s) begin
                    fault = 1'b1;
                end else if (!v) begin
                    state_n = FRONTPORCH;
                    fp_n    = T1;
                end else if (&vc_cnt) begin
                    fault = 1'b1;
                end else begin
                    vc_n = vc_cnt + V1;
                end
            end
            FRONTPORCH: begin
                if (v) begin
                    fault = 1'b1;
                end else if (s) begin
                    done    = 1'b1;
                    state_n = SYNC;
                    sn_n    = T1;
                end else if (&fp_cnt) begin
                    fault = 1'b1;
                end else begin
                    fp_n = fp_cnt + T1;
                end
            end
            default: begin
                state_n = IDLE;
                armed_n = 1'b0;
            end
        endcase
        // any violation drops back to a disarmed IDLE
        if (fault) begin
            state_n = IDLE;
            armed_n = 1'b0;
        end
    end

    assign sn_new = sn_cnt - T1;
    assign bp_new = bp_cnt - T1;
    assign fp_new = fp_cnt - T1;
    assign vl_new = vc_cnt - V1;

    assign same = (sn_new == bus.snsize_o) &&
                  (bp_new == bus.bpsize_o) &&
                  (fp_new == bus.fpsize_o) &&
                  (vl_new == bus.vlen_o);

    always_comb begin
        match_n = match;
        if (fault) begin
            match_n = '0;
        end else if (done) begin
            if (same && (match != '0)) begin
                match_n = (match >= LK) ? LK : match + M1;
            end else begin
                match_n = M1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            armed        <= 1'b0;
            sn_cnt       <= '0;
            bp_cnt       <= '0;
            fp_cnt       <= '0;
            vc_cnt       <= '0;
            match        <= '0;
            bus.snsize_o <= '0;
            bus.bpsize_o <= '0;
            bus.fpsize_o <= '0;
            bus.vlen_o   <= '0;
            bus.valid_o  <= 1'b0;
            bus.lock_o   <= 1'b0;
            bus.err_o    <= 1'b0;
        end else begin
            bus.valid_o <= bus.en_i & done;
            bus.err_o   <= bus.en_i & fault;
            if (bus.en_i) begin
                armed  <= armed_n;
                sn_cnt <= sn_n;
                bp_cnt <= bp_n;
                fp_cnt <= fp_n;
                vc_cnt <= vc_n;
                match  <= match_n;
                if (done) begin
                    bus.snsize_o <= sn_new;
                    bus.bpsize_o <= bp_new;
                    bus.fpsize_o <= fp_new;
                    bus.vlen_o   <= vl_new;
                end
                if (done || fault) begin
                    bus.lock_o <= (match_n >= LK);
                end
            end
        end
    end
endmodule

// File: tb/tb_vgalcd_tim_meas.sv
// Randomized bench for vgalcd_tim_meas against a run-length reference model.
// A second narrow instance exercises counter overflow.
module tb_vgalcd_tim_meas;
    localparam int LOCK = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   gap         = 0;
    bit   cmp_on      = 1'b0;

    always #5 clk = ~clk;

    vgalcd_tim_meas_if #(.TB_WIDTH(16), .VB_WIDTH(16)) m ();
    vgalcd_tim_meas_if #(.TB_WIDTH(4),  .VB_WIDTH(4))  n ();

    vgalcd_tim_meas #(.TB_WIDTH(16), .VB_WIDTH(16), .LOCK_CNT(LOCK)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (m)
    );

    vgalcd_tim_meas #(.TB_WIDTH(4), .VB_WIDTH(4), .LOCK_CNT(2)) dut_n (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (n)
    );

    // reference model: the period is a list of runs of identical samples
    typedef struct packed {
        logic [31:0] sn, bp, fp, vl;
    } per_t;

    logic [1:0]  run_sym [$];
    int unsigned run_len [$];
    per_t        done_q  [$];
    bit          meas  = 1'b0;
    bit          armed = 1'b0;
    logic [15:0] e_bp = '0, e_sn = '0, e_fp = '0, e_vl = '0;
    logic        e_valid = 1'b0, e_lock = 1'b0, e_err = 1'b0;

    task automatic model_tick(input logic [1:0] x);
        logic [1:0] want [5];
        int         last;
        int unsigned lim;
        bit         bad;
        per_t       t;
        want = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        bad  = 1'b0;
        if (!meas) begin
            if (!x[1]) begin
                armed = 1'b1;
            end else if (armed) begin
                meas  = 1'b1;
                armed = 1'b0;
                run_sym = '{2'b10};
                run_len = '{1};
            end
            return;
        end
        last = run_sym.size() - 1;
        lim  = (last == 2) ? 32'd65535 : 32'd65535;
        if (x == run_sym[last]) begin
            if (run_len[last] == lim) bad = 1'b1;
            else run_len[last] = run_len[last] + 1;
        end else if (x == want[last+1]) begin
            if (last + 1 == 4) begin
                t.sn = run_len[0] - 1;
                t.bp = run_len[1] - 1;
                t.vl = run_len[2] - 1;
                t.fp = run_len[3] - 1;
                done_q.push_back(t);
                if (done_q.size() > LOCK) void'(done_q.pop_front());
                e_lock = (done_q.size() >= LOCK);
                foreach (done_q[i]) if (done_q[i] != t) e_lock = 1'b0;
                e_sn = t.sn[15:0];
                e_bp = t.bp[15:0];
                e_fp = t.fp[15:0];
                e_vl = t.vl[15:0];
                e_valid = 1'b1;
                run_sym = '{2'b10};
                run_len = '{1};
            end else begin
                run_sym.push_back(x);
                run_len.push_back(1);
            end
        end else begin
            bad = 1'b1;
        end
        if (bad) begin
            e_err  = 1'b1;
            e_lock = 1'b0;
            meas   = 1'b0;
            armed  = 1'b0;
            done_q.delete();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas = 1'b0;
            armed = 1'b0;
            done_q.delete();
            run_sym.delete();
            run_len.delete();
            e_bp = '0; e_sn = '0; e_fp = '0; e_vl = '0;
            e_valid = 1'b0; e_lock = 1'b0; e_err = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_err   = 1'b0;
            if (m.en_i) model_tick({m.sync_i, m.vis_i});
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            vectors++;
            if ({m.bpsize_o, m.snsize_o, m.fpsize_o, m.vlen_o,
                 m.valid_o, m.lock_o, m.err_o} !==
                {e_bp, e_sn, e_fp, e_vl, e_valid, e_lock, e_err}) begin
                miscompares++;
                $display("FAIL model t=%0t got bp=%0d sn=%0d fp=%0d vl=%0d v=%b l=%b e=%b want bp=%0d sn=%0d fp=%0d vl=%0d v=%b l=%b e=%b",
                         $time, m.bpsize_o, m.snsize_o, m.fpsize_o, m.vlen_o,
                         m.valid_o, m.lock_o, m.err_o,
                         e_bp, e_sn, e_fp, e_vl, e_valid, e_lock, e_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic chk_main(input string name, input int bp, vl, fp, sn,
                            input logic vld, lck);
        chk({name, ".bp"},    32'(m.bpsize_o), 32'(bp));
        chk({name, ".vlen"},  32'(m.vlen_o),   32'(vl));
        chk({name, ".fp"},    32'(m.fpsize_o), 32'(fp));
        chk({name, ".sn"},    32'(m.snsize_o), 32'(sn));
        chk({name, ".valid"}, 32'(m.valid_o),  32'(vld));
        chk({name, ".lock"},  32'(m.lock_o),   32'(lck));
    endtask

    task automatic tick(input logic s, input logic v);
        for (int g = 0; g < gap; g++) begin
            m.en_i   = 1'b0;
            m.sync_i = 1'($urandom);
            m.vis_i  = 1'($urandom);
            @(negedge clk);
        end
        m.en_i   = 1'b1;
        m.sync_i = s;
        m.vis_i  = v;
        @(negedge clk);
        m.en_i = 1'b0;
    endtask

    task automatic tick_n(input logic s, input logic v);
        n.en_i   = 1'b1;
        n.sync_i = s;
        n.vis_i  = v;
        @(negedge clk);
        n.en_i = 1'b0;
    endtask

    task automatic period(input int sn, bp, vl, fp);
        repeat (sn) tick(1'b1, 1'b0);
        repeat (bp) tick(1'b0, 1'b0);
        repeat (vl) tick(1'b0, 1'b1);
        repeat (fp) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    int sn_l, bp_l, vl_l, fp_l, r;

    initial begin
        m.en_i = 1'b0; m.sync_i = 1'b0; m.vis_i = 1'b0;
        n.en_i = 1'b0; n.sync_i = 1'b0; n.vis_i = 1'b0;
        #1 rst_n = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_main("reset", 0, 0, 0, 0, 1'b0, 1'b0);
        chk("reset.err", 32'(m.err_o), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // periodic stream, continuous ticks
        gap = 0;
        repeat (3) tick(1'b0, 1'b0);
        period(2, 4, 10, 3);
        tick(1'b1, 1'b0);
        chk_main("t1.first", 3, 9, 2, 1, 1'b1, 1'b0);
        period(1, 4, 10, 3);
        tick(1'b1, 1'b0);
        chk_main("t1.second", 3, 9, 2, 1, 1'b1, 1'b1);

        // same stream, one tick every third clock
        do_reset();
        gap = 2;
        tick(1'b0, 1'b0);
        period(2, 4, 10, 3);
        tick(1'b1, 1'b0);
        chk_main("t2.first", 3, 9, 2, 1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2.valid_width", 32'(m.valid_o), 32'd0);
        period(1, 4, 10, 3);
        tick(1'b1, 1'b0);
        chk_main("t2.second", 3, 9, 2, 1, 1'b1, 1'b1);

        // visible during sync while locked
        gap = 0;
        tick(1'b1, 1'b1);
        chk("t3.err", 32'(m.err_o), 32'd1);
        chk_main("t3.hold", 3, 9, 2, 1, 1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("t3.err_width", 32'(m.err_o), 32'd0);
        period(2, 4, 10, 3);
        period(2, 4, 10, 3);
        tick(1'b1, 1'b0);
        chk_main("t3.relock", 3, 9, 2, 1, 1'b1, 1'b1);

        // visible length changes by one tick
        period(1, 4, 11, 3);
        tick(1'b1, 1'b0);
        chk_main("t4.change", 3, 10, 2, 1, 1'b1, 1'b0);
        period(1, 4, 11, 3);
        tick(1'b1, 1'b0);
        chk_main("t4.relock", 3, 10, 2, 1, 1'b1, 1'b1);

        // mid-sync start and reset in the middle of visible
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        period(0, 4, 10, 3);
        period(2, 4, 5, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_main("t6.in_reset", 0, 0, 0, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_main("t6.after_reset", 0, 0, 0, 0, 1'b0, 1'b0);
        period(0, 0, 5, 3);
        period(2, 4, 10, 3);
        chk("t6.no_early_valid", 32'(m.bpsize_o), 32'd0);
        tick(1'b1, 1'b0);
        chk_main("t6.fresh", 3, 9, 2, 1, 1'b1, 1'b0);

        // narrow counters: 15-tick max per phase
        do_reset();
        tick_n(1'b0, 1'b0);
        repeat (2)  tick_n(1'b1, 1'b0);
        repeat (14) tick_n(1'b0, 1'b0);
        repeat (3)  tick_n(1'b0, 1'b1);
        repeat (2)  tick_n(1'b0, 1'b0);
        tick_n(1'b1, 1'b0);
        chk("t5.valid", 32'(n.valid_o), 32'd1);
        chk("t5.bp", 32'(n.bpsize_o), 32'd13);
        chk("t5.vlen", 32'(n.vlen_o), 32'd2);
        tick_n(1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick_n(1'b0, 1'b0);
            chk("t5.ovf_err", 32'(n.err_o), (k == 16) ? 32'd1 : 32'd0);
            chk("t5.ovf_valid", 32'(n.valid_o), 32'd0);
        end
        chk("t5.hold_bp", 32'(n.bpsize_o), 32'd13);
        chk("t5.lock", 32'(n.lock_o), 32'd0);
        tick_n(1'b0, 1'b0);
        chk("t5.err_width", 32'(n.err_o), 32'd0);

        // randomized streams with repeats, glitches and resets
        sn_l = 2; bp_l = 4; vl_l = 10; fp_l = 3;
        for (int it = 0; it < 250; it++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            r = $urandom_range(0, 29);
            if (r == 0) begin
                do_reset();
            end else if (r < 4) begin
                tick(1'($urandom), 1'($urandom));
            end
            if (r < 10) begin
                sn_l = $urandom_range(1, 4);
                bp_l = $urandom_range(1, 5);
                vl_l = $urandom_range(1, 8);
                fp_l = $urandom_range(1, 4);
            end
            period(sn_l, bp_l, vl_l, fp_l);
        end
        gap = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
